// File: rtl/period_meas_pkg.sv
// Shared types, simulation/silicon constant sets and the output saturation
// helper for the pulse period meter.
package period_meas_pkg;

    typedef enum logic {
        STALLED = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [23:0] TIMEOUT_FAST = 24'h007271;
    localparam int          SHIFT_FAST   = 7;
    localparam logic [23:0] TIMEOUT_REAL = 24'hE4E1C0;
    localparam int          SHIFT_REAL   = 16;

    // Clamp x to the largest value representable in out_w bits.
    function automatic logic [31:0] sat_out(input logic [31:0] x, input int unsigned out_w);
        logic [31:0] lim;
        if (out_w >= 32'd32) begin
            lim = 32'hFFFF_FFFF;
        end else begin
            lim = (32'd1 << out_w) - 32'd1;
        end
        if (x > lim) begin
            sat_out = lim;
        end else begin
            sat_out = x;
        end
    endfunction

endpackage

// File: rtl/period_meas_edge_sync.sv
// Brings the asynchronous pulse input into the clk domain and produces a
// registered one-cycle strobe for each rising edge.
module edge_sync
    import period_meas_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_synced;
    logic                   r_prev;
    logic                   r_rise;

    // Synchroniser chain, a capture flop that isolates it from the detector, prev flop, edge strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= '0;
            r_synced <= 1'b0;
            r_prev   <= 1'b0;
            r_rise   <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], d};
            r_synced <= r_sync[SYNC_STAGES-1];
            r_prev   <= r_synced;
            r_rise   <= r_synced & ~r_prev;
        end
    end

    assign rise = r_rise;

endmodule

// File: rtl/period_meas.sv
// Pulse period meter: counts clk cycles between rising edges of sig_in and
// reports a scaled/saturated raw period, an exponential average and a stall flag.
module period_meas
    import period_meas_pkg::*;
#(
    parameter int               CNT_W       = 24,
    parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(TIMEOUT_REAL),
    parameter int               SHIFT       = SHIFT_REAL,
    parameter int               OUT_W       = 8,
    parameter int               AVG_SHIFT   = 2,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [OUT_W-1:0] per_raw,
    output logic [OUT_W-1:0] per_avg,
    output logic             per_vld,
    output logic             stalled,
    output logic [15:0]      edge_cnt
);

    localparam logic [OUT_W-1:0] STALL_VAL = OUT_W'(sat_out(32'(TIMEOUT >> SHIFT), OUT_W));
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_first;
    logic [OUT_W-1:0]   r_per_raw;
    logic [OUT_W-1:0]   r_per_avg;
    logic               r_per_vld;
    logic               r_stalled;
    logic [15:0]        r_edge_cnt;

    logic               w_rise;
    logic [OUT_W-1:0]   w_sample;
    logic signed [OUT_W:0] w_diff;
    logic signed [OUT_W:0] w_step;
    logic [OUT_W-1:0]   w_avg_next;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sig_in),
        .rise  (w_rise)
    );

    // Averaging error is formed one bit wider so the sign survives the arithmetic shift.
    assign w_sample   = OUT_W'(sat_out(32'(r_count >> SHIFT), OUT_W));
    assign w_diff     = $signed({1'b0, w_sample}) - $signed({1'b0, r_per_avg});
    assign w_step     = w_diff >>> AVG_SHIFT;
    assign w_avg_next = r_per_avg + OUT_W'(w_step);

    // Measurement FSM, interval counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= STALLED;
            r_count    <= '0;
            r_first    <= 1'b0;
            r_per_raw  <= STALL_VAL;
            r_per_avg  <= STALL_VAL;
            r_per_vld  <= 1'b0;
            r_stalled  <= 1'b1;
            r_edge_cnt <= 16'd0;
        end else begin
            r_per_vld <= 1'b0;
            if (en && w_rise) begin
                r_edge_cnt <= r_edge_cnt + 16'd1;
            end
            if (!en) begin
                r_state   <= STALLED;
                r_count   <= '0;
                r_stalled <= 1'b1;
            end else begin
                case (r_state)
                    STALLED: begin
                        r_count   <= '0;
                        r_stalled <= 1'b1;
                        // Previous edge time is unknown, so this edge only arms the counter.
                        if (w_rise) begin
                            r_state   <= MEASURE;
                            r_count   <= CNT_ONE;
                            r_first   <= 1'b1;
                            r_stalled <= 1'b0;
                        end
                    end
                    MEASURE: begin
                        r_stalled <= 1'b0;
                        if (w_rise) begin
                            r_per_raw <= w_sample;
                            r_per_vld <= 1'b1;
                            r_count   <= CNT_ONE;
                            if (r_first) begin
                                r_per_avg <= w_sample;
                                r_first   <= 1'b0;
                            end else begin
                                r_per_avg <= w_avg_next;
                            end
                        end else if (r_count == TIMEOUT) begin
                            r_state   <= STALLED;
                            r_per_raw <= STALL_VAL;
                            r_per_avg <= STALL_VAL;
                            r_per_vld <= 1'b1;
                            r_count   <= '0;
                            r_stalled <= 1'b1;
                        end else begin
                            r_count <= r_count + CNT_ONE;
                        end
                    end
                    default: begin
                        r_state   <= STALLED;
                        r_count   <= '0;
                        r_stalled <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign per_raw  = r_per_raw;
    assign per_avg  = r_per_avg;
    assign per_vld  = r_per_vld;
    assign stalled  = r_stalled;
    assign edge_cnt = r_edge_cnt;

endmodule
